// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the multiply/divide unit: operand width, funct3 op codes
// and FSM state encoding.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle through a single shared
// XLEN+1-bit adder, result returned on a valid/ready writeback port.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CALC  | XLEN shift-add (multiply) or restoring-divide iterations
// FIX   | sign correction and result selection
// DONE  | result held on wb_* until wb_ready
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd_addr,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic            neg_q, neg_d;

  muldiv_op_e      req_op;
  logic            accept, rs1_sgn, rs2_sgn, div_zero, div_ovf, special;
  logic [XLEN-1:0] rs1_abs, rs2_abs, special_res;

  logic            is_div_q, quo_bit;
  logic [XLEN:0]   add_x, add_y, add_s, mul_part;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  assign req_ready  = (state_q == ST_IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign wb_valid   = (state_q == ST_DONE);
  assign wb_data    = res_q;
  assign wb_rd_addr = rd_q;

  // Operands are converted to magnitudes at accept; neg_q records whether the result must be negated.
  assign req_op   = muldiv_op_e'(req_funct3);
  assign rs1_sgn  = req_rs1[XLEN-1] && (req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign rs2_sgn  = req_rs2[XLEN-1] && (req_op inside {OP_MULH, OP_DIV, OP_REM});
  assign rs1_abs  = rs1_sgn ? -req_rs1 : req_rs1;
  assign rs2_abs  = rs2_sgn ? -req_rs2 : req_rs2;
  assign div_zero = (req_rs2 == '0);
  assign div_ovf  = (req_op inside {OP_DIV, OP_REM}) &&
                    (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
  assign special  = req_funct3[2] && (div_zero || div_ovf);
  assign special_res = div_zero ? (req_funct3[1] ? req_rs1 : '1)
                                : (req_funct3[1] ? '0 : req_rs1);

  // Shared adder: multiply adds the multiplicand to the upper product half,
  // divide subtracts the divisor from the shifted partial remainder.
  assign is_div_q = op_q[2];
  assign add_x    = is_div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
  assign add_y    = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
  assign add_s    = add_x + add_y + {{XLEN{1'b0}}, is_div_q};
  assign mul_part = lo_q[0] ? add_s : {1'b0, hi_q};
  assign quo_bit  = !add_s[XLEN];

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          rd_d  = req_rd_addr;
          cnt_d = '0;
          neg_d = (req_op == OP_REM) ? rs1_sgn : (rs1_sgn ^ rs2_sgn);
          if (special) begin
            res_d   = special_res;
            state_d = ST_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = req_funct3[2] ? rs1_abs : rs2_abs;
            opnd_d  = req_funct3[2] ? rs2_abs : rs1_abs;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          hi_d = quo_bit ? add_s[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], quo_bit};
        end else begin
          hi_d = mul_part[XLEN:1];
          lo_d = {mul_part[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(XLEN-1)) state_d = ST_FIX;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      ST_FIX: begin
        res_d   = fix_res;
        state_d = ST_DONE;
      end
      default: begin
        if (wb_ready) state_d = ST_IDLE;
      end
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      rd_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference model feeds a scoreboard queue,
// results and latencies are compared as the unit retires them.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd_addr = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t scb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd_addr(req_rd_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sbv;
    logic ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sbv;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int exp_lat, input string name);
    exp_t e;
    int lat;
    e.rd = rd;
    e.data = model(f, a, b);
    scb.push_back(e);
    @(negedge clk);
    req_funct3 = f; req_rs1 = a; req_rs2 = b; req_rd_addr = rd;
    req_valid = 1'b1; wb_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready before accept got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    e = scb.pop_front();
    checks++;
    if (wb_data !== e.data) begin
      errors++; $display("FAIL %s wb_data got %h want %h", name, wb_data, e.data);
    end
    checks++;
    if (wb_rd_addr !== e.rd) begin
      errors++; $display("FAIL %s wb_rd_addr got %0d want %0d", name, wb_rd_addr, e.rd);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s retire wb_valid=%b req_ready=%b want 0/1", name, wb_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || wb_rd_addr !== 5'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b rd=%0d data=%h want 1/0/0/0", req_ready, wb_valid, wb_rd_addr, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, "mul_7x-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 34, "mulh_min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 34, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 34, "mulhsu_-1x2");
    run_op(3'b000, 32'd0, 32'h1234_5678, 5'd0, 34, "mul_rd0");
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 34, "div_-7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 34, "rem_-7/2");
    run_op(3'b101, 32'd100, 32'd7, 5'd12, 34, "divu_100/7");
    run_op(3'b111, 32'd100, 32'd7, 5'd13, 34, "remu_100/7");
  endtask

  task automatic test_special();
    run_op(3'b100, 32'd5, 32'd0, 5'd14, 1, "div_by0");
    run_op(3'b110, 32'd5, 32'd0, 5'd15, 1, "rem_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, "rem_ovf");
    run_op(3'b101, 32'd9, 32'd0, 5'd18, 1, "divu_by0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      int lat;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      run_op(f, a, b, 5'($urandom_range(0, 31)), lat, "random");
    end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      run_op(3'(i + 4), 32'd1000 + 32'(i), 32'd13, 5'(20 + i), 34, "b2b_div");
  endtask

  task automatic test_stall();
    exp_t e;
    int lat;
    e.rd = 5'd9;
    e.data = model(3'b101, 32'd100, 32'd7);
    scb.push_back(e);
    @(negedge clk);
    req_funct3 = 3'b101; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd_addr = 5'd9;
    req_valid = 1'b1; wb_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = scb.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== e.data) begin
      errors++; $display("FAIL stall result vld=%b data=%h want 1/%h", wb_valid, wb_data, e.data);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd_addr !== e.rd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d vld=%b data=%h rd=%0d rdy=%b want 1/%h/%0d/0",
                 i, wb_valid, wb_data, wb_rd_addr, req_ready, e.data, e.rd);
      end
    end
    @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release vld=%b rdy=%b want 0/1", wb_valid, req_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    req_funct3 = 3'b000; req_rs1 = 32'h1234_5678; req_rs2 = 32'h9ABC_DEF0; req_rd_addr = 5'd3;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_calc wb_valid got %b want 0", wb_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got %b want 1", req_ready);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_result wb_valid cycles got %0d want 0", seen);
    end
    run_op(3'b000, 32'd3, 32'd4, 5'd7, 34, "mul_after_flush");
    @(negedge clk);
    flush = 1'b1;
    req_funct3 = 3'b100; req_rs1 = 32'd5; req_rs2 = 32'd0; req_rd_addr = 5'd4;
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_accept wb_valid got %b want 0", wb_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_funct3 = 3'b100; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd_addr = 5'd11;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || wb_rd_addr !== 5'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b rd=%0d data=%h want 1/0/0/0", req_ready, wb_valid, wb_rd_addr, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd30, 34, "rem_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
